// File: rtl/csa_seq_ctrl_if.sv
// Handshake bundle for the sequential carry-select adder.
// Requester/consumer side is master, adder side is slave.
interface csa_seq_ctrl_if #(
  parameter int WIDTH = 12
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, op1, op2, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, op1, op2, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/csa_seq_ctrl.sv
// Sequential WIDTH-bit adder reusing one SLICE-bit carry-select slice,
// least significant slice first, with valid/ready in and out.
module csa_seq_ctrl #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3
) (
  input  logic         clk,
  input  logic         rst,
  csa_seq_ctrl_if.slave bus,
  output logic         busy
);
  localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("csa_seq_ctrl: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             rdy_q;
  logic             vld_q;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   res0;
  logic [SLICE:0]   res1;
  logic [SLICE:0]   res;
  logic             last;

  // Both carry hypotheses are formed; the registered carry picks one.
  always_comb begin
    a_sl = a_q[SLICE*int'(idx_q) +: SLICE];
    b_sl = b_q[SLICE*int'(idx_q) +: SLICE];
    res0 = {1'b0, a_sl} + {1'b0, b_sl};
    res1 = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(1);
    res  = carry_q ? res1 : res0;
    last = (idx_q == IW'(N-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.op1;
            b_q     <= bus.op2;
            carry_q <= bus.cin;
            idx_q   <= '0;
            state   <= RUN;
            rdy_q   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          sum_q[SLICE*int'(idx_q) +: SLICE] <= res[SLICE-1:0];
          carry_q <= res[SLICE];
          if (last) begin
            cout_q <= res[SLICE];
            idx_q  <= '0;
            state  <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          // Result is presented one cycle after the final slice settles.
          if (!vld_q) begin
            vld_q <= 1'b1;
          end else if (bus.out_ready) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: doc/csa_seq_ctrl.md
CSA_SEQ_CTRL -- requirements
Module: csa_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, the operand and sum width in bits.
REQ-002 The block SHALL have parameter SLICE, default 3, the width of the internal carry-select adder slice.
REQ-003 WIDTH SHALL be an integer multiple of SLICE, with N = WIDTH/SLICE >= 1; any other combination is illegal, and the block SHALL flag it at elaboration.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  requester presents an operation.
REQ-007 in_ready  out  1  block can accept an operation.
REQ-008 op1  in  WIDTH  first operand.
REQ-009 op2  in  WIDTH  second operand.
REQ-010 cin  in  1  carry-in of the operation.
REQ-011 out_valid  out  1  the result is available.
REQ-012 out_ready  in  1  the consumer takes the result.
REQ-013 sum  out  WIDTH  registered result, (op1+op2+cin) mod 2^WIDTH.
REQ-014 cout  out  1  registered carry-out of the full WIDTH-bit addition.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The block SHALL time-multiplex one SLICE-bit carry-select adder slice to compute a WIDTH-bit sum over N cycles, starting with the least significant slice.
REQ-017 The adder slice SHALL compute both the carry-0 and carry-1 results and select between them with the registered carry; results SHALL be bit-exact to binary addition.
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 IDLE: in_ready=1, out_valid=0; when in_valid&&in_ready, the block SHALL capture op1, op2 and cin into internal registers, clear the slice index to 0, and go to RUN.
REQ-020 RUN: each cycle the block SHALL add slice[idx] of the captured operands with the carry register, write the result into sum[idx*SLICE +: SLICE], load the slice carry-out into the carry register, and increment idx.
REQ-021 RUN: in the cycle where idx = N-1, the block SHALL load cout with the slice carry-out and go to DONE.
REQ-022 DONE: out_valid=1; sum and cout SHALL hold stable until out_valid&&out_ready; on that handshake the block SHALL go to IDLE.
REQ-023 Latency: if the accept handshake is at edge T, out_valid SHALL first be high after edge T+N+1.
REQ-024 Throughput: at most one operation per N+2 cycles; in_ready SHALL NOT be asserted in the same cycle as the output handshake.
REQ-025 in_ready SHALL be 0 in RUN and DONE; changes on op1, op2, cin and in_valid outside the accept cycle SHALL NOT affect the result.
REQ-026 N=1 (SLICE=WIDTH) SHALL be supported: RUN lasts one cycle.
REQ-027 In RUN, sum bits not yet written SHALL hold their previous values; only the values in DONE are architecturally defined.
REQ-028 out_ready SHALL be ignored outside DONE.

Reset
REQ-029 When rst=1 at an edge, in any state including mid-RUN, the block SHALL go to IDLE, discard any in-flight operation, and clear sum, cout, the carry register and idx to 0.
REQ-030 After reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
REQ-031 Reset SHALL take priority over all handshakes in the same cycle.

Verification (WIDTH=12, SLICE=3, N=4)
REQ-032 op1=0x123, op2=0x456, cin=1 accepted at T -> out_valid after T+5, sum=0x57A, cout=0.
REQ-033 op1=0xFFF, op2=0x001, cin=0 -> sum=0x000, cout=1; op1=0x0FF, op2=0x001 -> sum=0x100, cout=0 (carry crosses slices).
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, sum and cout stable, in_ready=0, busy=1; the op1/op2 inputs toggle without effect.
REQ-035 Assert rst when idx=2 -> next cycle in_ready=1, out_valid=0, busy=0, sum=0; a new operation then completes correctly.
REQ-036 Hold in_valid=1 with two queued operations -> the second is accepted only in IDLE, after the first output handshake; both results are correct.
REQ-037 Run 10k random op1, op2, cin with random out_ready stalls -> all results match the reference model (op1+op2+cin), and the latency is exactly as in REQ-023.
